// File: rtl/list_sum_sequencer_pkg.sv
// Shared definitions for the linked-list summing controller: state encoding
// and the datapath select constants used by both controller and datapath.
package list_sum_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_ADD   = 3'd2,
        ST_LINK  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam logic SEL_ADDR_VALUE = 1'b0;
    localparam logic SEL_ADDR_LINK  = 1'b1;
    localparam logic SEL_SUM_CLEAR  = 1'b0;
    localparam logic SEL_SUM_ACC    = 1'b1;
    localparam logic SEL_NEXT_CLEAR = 1'b0;
    localparam logic SEL_NEXT_MEM   = 1'b1;

    // States in which a new run may be requested and launched.
    function automatic logic is_idle_like(input state_e s);
        logic r;
        case (s)
            ST_IDLE, ST_DONE, ST_ERR: r = 1'b1;
            default:                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/list_sum_sequencer_rise_detect.sv
// Rising-edge detector for the start switch; the previous level is registered
// and reset high so a switch already on at reset release is not taken as an edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-level register for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/list_sum_sequencer.sv
// Step-gated controller for the linked-list summing datapath: sequences clear,
// add and link steps per node, counts nodes and flags over-long or cyclic lists.
module list_sum_sequencer
    import list_sum_sequencer_pkg::*;
#(
    parameter int MAX_NODES = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  logic             start,
    input  logic             abort,
    input  logic             next_zero,
    output logic             LOAD_SUM,
    output logic             LOAD_NEXT,
    output logic             SUM_SEL,
    output logic             NEXT_SEL,
    output logic             ADDR_SEL,
    output logic             busy,
    output logic             DONE,
    output logic             err,
    output logic [CNT_W-1:0] node_cnt
);

    state_e           state_q, state_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_rise;
    logic             idle_like;
    logic             load_sum_dec, load_next_dec;
    logic             sum_sel_dec, next_sel_dec, addr_sel_dec;
    logic             busy_dec, done_dec, err_dec;

    rise_detect u_rise (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (start),
        .rise_o (start_rise)
    );

    assign idle_like = is_idle_like(state_q);

    // Next-state logic; abort is not step-gated and overrides any transition.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else if (step_en) begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (pend_q) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_CLEAR: state_d = ST_ADD;
                ST_ADD:   state_d = ST_LINK;
                ST_LINK:  state_d = ST_CHECK;
                ST_CHECK: begin
                    if (next_zero) begin
                        state_d = ST_DONE;
                    end else if (cnt_q == CNT_W'(MAX_NODES)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_ADD;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Pending-start flag: an edge seen between runs waits here for the next step.
    always_comb begin
        pend_d = pend_q;
        if (abort) begin
            pend_d = 1'b0;
        end else if (idle_like && step_en && pend_q) begin
            pend_d = 1'b0;
        end else if (idle_like && start_rise) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Node counter; the CHECK limit test keeps it from ever passing MAX_NODES.
    always_comb begin
        cnt_d = cnt_q;
        if (!abort && step_en && (state_q == ST_CLEAR)) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (!abort && step_en && (state_q == ST_ADD)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Moore output decode of the current state.
    always_comb begin
        load_sum_dec  = 1'b0;
        load_next_dec = 1'b0;
        sum_sel_dec   = SEL_SUM_CLEAR;
        next_sel_dec  = SEL_NEXT_CLEAR;
        addr_sel_dec  = SEL_ADDR_VALUE;
        busy_dec      = 1'b0;
        done_dec      = 1'b0;
        err_dec       = 1'b0;
        case (state_q)
            ST_IDLE:  busy_dec = 1'b0;
            ST_CLEAR: begin
                busy_dec      = 1'b1;
                load_sum_dec  = 1'b1;
                load_next_dec = 1'b1;
            end
            ST_ADD: begin
                busy_dec     = 1'b1;
                load_sum_dec = 1'b1;
                sum_sel_dec  = SEL_SUM_ACC;
                addr_sel_dec = SEL_ADDR_VALUE;
            end
            ST_LINK: begin
                busy_dec      = 1'b1;
                load_next_dec = 1'b1;
                next_sel_dec  = SEL_NEXT_MEM;
                addr_sel_dec  = SEL_ADDR_LINK;
            end
            ST_CHECK: busy_dec = 1'b1;
            ST_DONE:  done_dec = 1'b1;
            ST_ERR:   err_dec  = 1'b1;
            default:  busy_dec = 1'b0;
        endcase
    end

    // State, pending-start and node-count registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pend_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign LOAD_SUM  = load_sum_dec & step_en;
    assign LOAD_NEXT = load_next_dec & step_en;
    assign SUM_SEL   = sum_sel_dec;
    assign NEXT_SEL  = next_sel_dec;
    assign ADDR_SEL  = addr_sel_dec;
    assign busy      = busy_dec;
    assign DONE      = done_dec;
    assign err       = err_dec;
    assign node_cnt  = cnt_q;

endmodule

// File: tb/tb_list_sum_sequencer.sv
// Bench for list_sum_sequencer: models the datapath and list memory, walks each
// list with a plain reference loop and compares sum, count, flags and step latency.
module tb_list_sum_sequencer;

    localparam int MAXN = 4;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       hold;
    logic       step_en;
    logic       start;
    logic       abort;
    logic       next_zero;
    logic       LOAD_SUM, LOAD_NEXT, SUM_SEL, NEXT_SEL, ADDR_SEL;
    logic       busy, DONE, err;
    logic [7:0] node_cnt;

    logic [7:0]  mem [0:255];
    logic [15:0] dp_sum;
    logic [7:0]  dp_next;
    logic [7:0]  dp_addr;
    int          step_cnt;
    int          s0;
    int          n_cmp;
    int          n_fail;
    int          div;

    list_sum_sequencer #(.MAX_NODES(MAXN), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .step_en   (step_en),
        .start     (start),
        .abort     (abort),
        .next_zero (next_zero),
        .LOAD_SUM  (LOAD_SUM),
        .LOAD_NEXT (LOAD_NEXT),
        .SUM_SEL   (SUM_SEL),
        .NEXT_SEL  (NEXT_SEL),
        .ADDR_SEL  (ADDR_SEL),
        .busy      (busy),
        .DONE      (DONE),
        .err       (err),
        .node_cnt  (node_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Divider: one tick every third clock, changed just after the rising edge.
    initial begin
        tick = 1'b0;
        div  = 0;
        forever begin
            @(posedge clk);
            #1;
            div  = (div == 2) ? 0 : div + 1;
            tick = (div == 2);
        end
    end

    assign step_en   = tick & ~hold;
    assign dp_addr   = ADDR_SEL ? dp_next + 8'd1 : dp_next;
    assign next_zero = (dp_next == 8'd0);

    // Datapath model: sum and next registers driven by the controller.
    always @(posedge clk) begin
        if (!rst) begin
            dp_sum  <= 16'd0;
            dp_next <= 8'd0;
        end else begin
            if (LOAD_SUM)  dp_sum  <= SUM_SEL ? dp_sum + 16'(mem[dp_addr]) : 16'd0;
            if (LOAD_NEXT) dp_next <= NEXT_SEL ? mem[dp_addr] : 8'd0;
        end
    end

    always @(posedge clk) begin
        if (step_en) step_cnt <= step_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    endtask

    // Walk the list from address 0 the way the hardware should: add value,
    // follow link, stop on null link or once MAXN nodes have been added.
    task automatic ref_walk(output logic [15:0] s, output int c, output bit e);
        logic [7:0] a;
        a = 8'd0; s = 16'd0; c = 0; e = 1'b0;
        for (int g = 0; g < 1000; g++) begin
            c++;
            s = s + 16'(mem[a]);
            a = mem[a + 8'd1];
            if (a == 8'd0) break;
            if (c == MAXN) begin
                e = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_run(input string tag);
        int k;
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        k = 0;
        while (!busy && k < 30) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_clr"}, 32'({DONE, err}), 32'd0);
        s0 = step_cnt;
    endtask

    task automatic finish_run(input string tag);
        int          k;
        logic [15:0] es;
        int          ec;
        bit          ee;
        ref_walk(es, ec, ee);
        k = 0;
        while (!(DONE || err) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(DONE), 32'(!ee));
        check({tag, "_err"}, 32'(err), 32'(ee));
        check({tag, "_cnt"}, 32'(node_cnt), 32'(ec));
        check({tag, "_sum"}, 32'(dp_sum), 32'(es));
        check({tag, "_steps"}, 32'(step_cnt - s0), 32'(1 + 3 * ec));
    endtask

    task automatic build_list2();
        clear_mem();
        mem[0] = 8'd5; mem[1] = 8'd4;
        mem[4] = 8'd7; mem[5] = 8'd8;
        mem[8] = 8'd9; mem[9] = 8'd0;
    endtask

    task automatic build_random(input int n, input bit cyc);
        logic [7:0] addr [8];
        bit         used [128];
        int         idx;
        clear_mem();
        for (int i = 0; i < 128; i++) used[i] = 1'b0;
        used[0] = 1'b1;
        addr[0] = 8'd0;
        for (int i = 1; i < n; i++) begin
            do idx = int'($urandom_range(1, 127)); while (used[idx]);
            used[idx] = 1'b1;
            addr[i] = 8'(idx * 2);
        end
        for (int i = 0; i < n; i++) begin
            mem[addr[i]] = 8'($urandom_range(0, 255));
            if (i < n - 1)  mem[addr[i] + 8'd1] = addr[i + 1];
            else if (cyc)   mem[addr[i] + 8'd1] = addr[$urandom_range(1, n - 1)];
            else            mem[addr[i] + 8'd1] = 8'd0;
        end
    endtask

    initial begin
        int         k;
        int         viol;
        logic [13:0] snap;
        logic [15:0] snap_sum;
        int         n;
        bit         cyc;

        n_cmp = 0; n_fail = 0; step_cnt = 0; s0 = 0;
        hold = 1'b0; abort = 1'b0; start = 1'b1; rst = 1'b0;
        clear_mem();

        // 1: reset with start held high, then no run after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flags", 32'({busy, DONE, err}), 32'd0);
        check("rst_cnt", 32'(node_cnt), 32'd0);
        check("rst_loads", 32'({LOAD_SUM, LOAD_NEXT}), 32'd0);
        check("rst_sels", 32'({SUM_SEL, NEXT_SEL, ADDR_SEL}), 32'd0);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_norun", 32'({busy, DONE, err}), 32'd0);

        // 2: three-node list.
        build_list2();
        start_run("t2");
        finish_run("t2");

        // 3: cyclic list hits the node limit, then a fresh run clears err.
        clear_mem();
        mem[0] = 8'd1; mem[1] = 8'd4;
        mem[4] = 8'd2; mem[5] = 8'd8;
        mem[8] = 8'd3; mem[9] = 8'd4;
        start_run("t3a");
        finish_run("t3a");
        start_run("t3b");
        finish_run("t3b");

        // Exactly MAXN nodes completes without error.
        clear_mem();
        mem[0]  = 8'd10; mem[1]  = 8'd2;
        mem[2]  = 8'd20; mem[3]  = 8'd6;
        mem[6]  = 8'd30; mem[7]  = 8'd10;
        mem[10] = 8'd40; mem[11] = 8'd0;
        start_run("tmax");
        finish_run("tmax");

        // 4: abort in LINK on the same clock as a start rise.
        build_list2();
        start_run("t4");
        start = 1'b0;
        k = 0;
        while (!(busy && ADDR_SEL) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("t4_link", 32'(ADDR_SEL), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("t4_abort", 32'({busy, DONE, err}), 32'd0);
        check("t4_cnt", 32'(node_cnt), 32'd1);
        repeat (12) @(negedge clk);
        check("t4_nopend", 32'(busy), 32'd0);
        start_run("t4b");
        finish_run("t4b");

        // 5: step_en held low for 50 clocks in ADD.
        build_list2();
        start_run("t5");
        k = 0;
        while (!(busy && SUM_SEL && !ADDR_SEL) && k < 100) begin
            @(negedge clk);
            k++;
        end
        hold = 1'b1;
        snap = {busy, DONE, err, node_cnt, SUM_SEL, NEXT_SEL, ADDR_SEL};
        snap_sum = dp_sum;
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (LOAD_SUM || LOAD_NEXT) viol++;
            if ({busy, DONE, err, node_cnt, SUM_SEL, NEXT_SEL, ADDR_SEL} !== snap) viol++;
            if (dp_sum !== snap_sum) viol++;
        end
        check("t5_frozen", 32'(viol), 32'd0);
        hold = 1'b0;
        finish_run("t5");

        // 6: single node; start toggled while busy must be ignored.
        clear_mem();
        mem[0] = 8'hFF; mem[1] = 8'd0;
        start_run("t6");
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        finish_run("t6");
        repeat (20) @(negedge clk);
        check("t6_hold", 32'({busy, DONE}), 32'd1);

        // Randomized lists, some cyclic, some longer than MAXN.
        for (int r = 0; r < 10; r++) begin
            n   = int'($urandom_range(1, 6));
            cyc = (n >= 2) && ($urandom_range(0, 3) == 0);
            build_random(n, cyc);
            start_run("rnd");
            finish_run("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
